fir3_out_serializer: RTL and testbench

- Sink for the 3-parallel FIR output block (y3k, y3k_1, y3k_2). Buffers whole blocks and re-emits them one sample per handshake in time order (3k, 3k+1, 3k+2).
- Sits between the parallel FIR core and single-rate downstream logic (DAC interface, checker, serial link).
- Valid/ready on both sides. A FIFO of blocks absorbs downstream stalls.

---
 rtl/fir3_pkg.sv | 44 ++++
 rtl/fir3_blk_fifo.sv | 52 +++++
 rtl/fir3_out_serializer.sv | 104 ++++++++++
 tb/tb_fir3_out_serializer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir3_pkg.sv
// Shared types and helpers for the 3-parallel FIR output serializer.
package fir3_pkg;

  localparam int unsigned NPAR   = 3;
  localparam int unsigned PKG_DW = 16;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_t;

  // One parallel output block; s0 is the earliest sample (n = 3k).
  typedef struct packed {
    logic signed [PKG_DW-1:0] s2;
    logic signed [PKG_DW-1:0] s1;
    logic signed [PKG_DW-1:0] s0;
  } blk_t;

  // Round-half-up by dropping 'drop' LSBs, then clamp to a signed 'ow'-bit range.
  function automatic logic signed [31:0] rnd_sat(input logic signed [31:0] x,
                                                 input int unsigned drop,
                                                 input int unsigned ow,
                                                 output logic sat);
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t = {{32{x[31]}}, x};
    if (drop != 0) t = t + (64'sd1 <<< (drop - 1));
    t   = t >>> drop;
    hi  = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (ow - 1));
    sat = 1'b0;
    if (t > hi) begin
      t   = hi;
      sat = 1'b1;
    end else if (t < lo) begin
      t   = lo;
      sat = 1'b1;
    end
    return t[31:0];
  endfunction

endpackage

// File: rtl/fir3_blk_fifo.sv
// Generic DEPTH-entry block FIFO with occupancy count and synchronous flush.
module fir3_blk_fifo #(
  parameter int unsigned W     = 48,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (i_pop && !i_push) r_count <= r_count - 1'b1;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fir3_out_serializer.sv
// Buffers 3-sample FIR blocks and emits them serially in time order.
// Optional FIR3_OUT_SERIALIZER_RNDSAT_EN: round/saturate to OW bits and add sat_flag.
module fir3_out_serializer
  import fir3_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned OW        = 16,
  parameter int unsigned BLK_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          blk_valid,
  output logic                          blk_ready,
  input  logic signed [DW-1:0]          y3k,
  input  logic signed [DW-1:0]          y3k_1,
  input  logic signed [DW-1:0]          y3k_2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OW-1:0]          out_data,
  output logic [1:0]                    out_phase,
`ifdef FIR3_OUT_SERIALIZER_RNDSAT_EN
  output logic                          sat_flag,
`endif
  output logic [$clog2(BLK_DEPTH):0]    level
);

  logic [NPAR*DW-1:0]          w_head;
  logic [$clog2(BLK_DEPTH):0]  w_count;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_hs;
  logic                        w_pop;
  logic signed [DW-1:0]        w_sample;
  phase_t                      r_phase;
  phase_t                      w_phase_d;

  assign blk_ready = !w_full && !flush;
  assign out_valid = !w_empty;
  assign w_push    = blk_valid && blk_ready;
  assign w_hs      = out_valid && out_ready;
  assign w_pop     = w_hs && (r_phase == PH2);

  fir3_blk_fifo #(
    .W     (NPAR * DW),
    .DEPTH (BLK_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_wdata ({y3k_2, y3k_1, y3k}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_phase <= PH0;
    else     r_phase <= w_phase_d;
  end

  always_comb begin
    w_phase_d = r_phase;
    if (flush) begin
      w_phase_d = PH0;
    end else if (w_hs) begin
      case (r_phase)
        PH0:     w_phase_d = PH1;
        PH1:     w_phase_d = PH2;
        default: w_phase_d = PH0;
      endcase
    end
  end

  always_comb begin
    case (r_phase)
      PH1:     w_sample = w_head[2*DW-1:DW];
      PH2:     w_sample = w_head[3*DW-1:2*DW];
      default: w_sample = w_head[DW-1:0];
    endcase
  end

`ifdef FIR3_OUT_SERIALIZER_RNDSAT_EN
  logic signed [31:0] w_rs;
  logic               w_sat;

  always_comb begin
    w_sat    = 1'b0;
    w_rs     = rnd_sat(32'(w_sample), DW - OW, OW, w_sat);
    out_data = w_rs[OW-1:0];
    sat_flag = w_sat;
  end
`else
  assign out_data = w_sample[OW-1:0];
`endif

  assign out_phase = r_phase;
  assign level     = w_count;

endmodule

// File: tb/tb_fir3_out_serializer.sv
// Directed self-checking bench for fir3_out_serializer (honours FIR3_OUT_SERIALIZER_RNDSAT_EN).
module tb_fir3_out_serializer;
  import fir3_pkg::*;

  localparam int unsigned DW = 16;
`ifdef FIR3_OUT_SERIALIZER_RNDSAT_EN
  localparam int unsigned OW = 8;
`else
  localparam int unsigned OW = 16;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 blk_valid;
  logic                 blk_ready;
  logic signed [DW-1:0] y3k, y3k_1, y3k_2;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic [1:0]           out_phase;
  logic [1:0]           level;
`ifdef FIR3_OUT_SERIALIZER_RNDSAT_EN
  logic                 sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir3_out_serializer #(
    .DW        (DW),
    .OW        (OW),
    .BLK_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .y3k       (y3k),
    .y3k_1     (y3k_1),
    .y3k_2     (y3k_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_phase (out_phase),
`ifdef FIR3_OUT_SERIALIZER_RNDSAT_EN
    .sat_flag  (sat_flag),
`endif
    .level     (level)
  );

  // Expected serial value for an input sample.
  function automatic int cv(int x);
`ifdef FIR3_OUT_SERIALIZER_RNDSAT_EN
    int t;
    t = (x + 128) >>> 8;
    if (t > 127)  t = 127;
    if (t < -128) t = -128;
    return t;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_blk(input blk_t b);
    y3k   = b.s0;
    y3k_1 = b.s1;
    y3k_2 = b.s2;
  endtask

  task automatic chk_out(input string tag, input int data, input int ph);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"},  out_data,  cv(data));
    chk({tag, "_phase"}, out_phase, ph);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach summary, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b, e, gaps;
    bit acc, started;

    rst = 1'b1; flush = 1'b0; blk_valid = 1'b0; out_ready = 1'b0;
    y3k = '0; y3k_1 = '0; y3k_2 = '0;
    #12;
    chk("rst_blk_ready", blk_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_phase", out_phase, 0);
    chk("rst_level",     level,     0);
    @(negedge clk);
    rst = 1'b0;

    // Single block, out_ready high throughout.
    out_ready = 1'b1;
    set_blk('{s0: 16'sd10, s1: -16'sd20, s2: 16'sd30});
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    chk_out("t1_c1", 10, 0);
    chk("t1_ready1", blk_ready, 1);
    step();
    chk_out("t1_c2", -20, 1);
    step();
    chk_out("t1_c3", 30, 2);
    chk("t1_ready3", blk_ready, 1);
    step();
    chk("t1_c4_valid", out_valid, 0);
    chk("t1_c4_level", level, 0);

    // Backpressure fill: third block waits for a pop.
    out_ready = 1'b0;
    set_blk('{s0: 16'sd1, s1: 16'sd2, s2: 16'sd3});
    blk_valid = 1'b1;
    step();
    chk("t2_level1", level, 1);
    set_blk('{s0: 16'sd4, s1: 16'sd5, s2: 16'sd6});
    step();
    chk("t2_level2", level, 2);
    chk("t2_full_ready", blk_ready, 0);
    set_blk('{s0: 16'sd7, s1: 16'sd8, s2: 16'sd9});
    step();
    chk("t2_held_level", level, 2);
    chk("t2_held_ready", blk_ready, 0);
    chk_out("t2_held", 1, 0);
    out_ready = 1'b1;
    step(); chk_out("t2_a1", 2, 1);
    step(); chk_out("t2_a2", 3, 2);
    chk("t2_a2_ready", blk_ready, 0);
    step(); chk_out("t2_b0", 4, 0);
    chk("t2_pop_level", level, 1);
    chk("t2_pop_ready", blk_ready, 1);
    step(); chk_out("t2_b1", 5, 1);
    chk("t2_c_push_level", level, 2);
    blk_valid = 1'b0;
    step(); chk_out("t2_b2", 6, 2);
    step(); chk_out("t2_c0", 7, 0);
    step(); chk_out("t2_c1", 8, 1);
    step(); chk_out("t2_c2", 9, 2);
    step(); chk("t2_empty", out_valid, 0);

    // Stall mid-block at phase 1.
    set_blk('{s0: 16'sd10, s1: -16'sd20, s2: 16'sd30});
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    chk_out("t3_p0", 10, 0);
    step();
    chk_out("t3_p1", -20, 1);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("t3_stall", -20, 1);
    end
    out_ready = 1'b1;
    step(); chk_out("t3_p2", 30, 2);
    step(); chk("t3_empty", out_valid, 0);

    // Streaming 8 blocks through a 2-deep buffer.
    b = 0; e = 0; gaps = 0; started = 1'b0;
    for (int cyc = 0; cyc < 60 && e < 24; cyc++) begin
      blk_valid = (b < 8);
      y3k   = 16'(3 * b);
      y3k_1 = 16'(3 * b + 1);
      y3k_2 = 16'(3 * b + 2);
      acc = blk_valid && blk_ready;
      step();
      if (acc) b++;
      if (out_valid) begin
        chk("t4_data",  out_data,  cv(e));
        chk("t4_phase", out_phase, e % 3);
        e++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
    end
    blk_valid = 1'b0;
    chk("t4_count", e, 24);
    chk("t4_gaps", gaps, 0);
    step();
    chk("t4_empty", out_valid, 0);

    // Flush at phase 1 with two blocks stored.
    out_ready = 1'b0;
    set_blk('{s0: 16'sd100, s1: 16'sd101, s2: 16'sd102});
    blk_valid = 1'b1;
    step();
    set_blk('{s0: 16'sd200, s1: 16'sd201, s2: 16'sd202});
    step();
    blk_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk_out("t5_pre", 101, 1);
    chk("t5_pre_level", level, 2);
    flush = 1'b1;
    blk_valid = 1'b1;
    #1;
    chk("t5_flush_ready", blk_ready, 0);
    step();
    flush = 1'b0;
    blk_valid = 1'b0;
    chk("t5_post_valid", out_valid, 0);
    chk("t5_post_level", level, 0);
    chk("t5_post_phase", out_phase, 0);

    // Asynchronous reset between edges.
    out_ready = 1'b0;
    set_blk('{s0: 16'sd1, s1: 16'sd2, s2: 16'sd3});
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    chk("t6_pre_valid", out_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_phase", out_phase, 0);
    chk("t6_rst_data",  out_data,  0);
    chk("t6_rst_ready", blk_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    set_blk('{s0: 16'sd5, s1: 16'sd6, s2: 16'sd7});
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    chk_out("t6_r0", 5, 0);
    step(); chk_out("t6_r1", 6, 1);
    step(); chk_out("t6_r2", 7, 2);
    step(); chk("t6_empty", out_valid, 0);

`ifdef FIR3_OUT_SERIALIZER_RNDSAT_EN
    // Rounding and saturation corners.
    set_blk('{s0: 16'sh7FFF, s1: 16'sh0180, s2: -16'sd32768});
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    chk("t7_max_data", out_data, 127);
    chk("t7_max_sat",  sat_flag, 1);
    step();
    chk("t7_rnd_data", out_data, 2);
    chk("t7_rnd_sat",  sat_flag, 0);
    step();
    chk("t7_min_data", out_data, -128);
    chk("t7_min_sat",  sat_flag, 0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
